// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// The frame state enum, header field widths and the header packing function live here.
package uart_tx_sched_pkg;

  localparam int SEQ_W    = 4;
  localparam int HDR_CH_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

  // Header byte: frame sequence number in the high nibble, channel in the low nibble.
  function automatic logic [7:0] hdr_pack(input logic [SEQ_W-1:0]    seq,
                                          input logic [HDR_CH_W-1:0] ch);
    return {seq, ch};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel found
// when scanning upward from ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any
);

  // Scan NUM_CH slots starting at ptr; the first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: shares one UART byte interface between NUM_CH record
// sources. A round-robin grant latches one REC_BYTES record, which is sent as
// a header byte {seq, ch} followed by the payload bytes, LSB byte first.
// Optional: define UART_TX_SCHED_CHECKSUM_EN to append an XOR checksum byte
// covering the header and the payload.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int REC_BYTES = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH*REC_BYTES*8-1:0] req_data,
  output logic [NUM_CH-1:0]             req_ack,
  output logic [7:0]                    tx_data,
  output logic                          tx_ready,
  input  logic                          tx_ack,
  output logic                          busy
);

  localparam int REC_BITS = REC_BYTES * 8;
  localparam int CNT_W    = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(REC_BYTES - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  state_t              state;
  logic [CH_W-1:0]     rr_ptr;
  logic [SEQ_W-1:0]    seq;
  logic [CNT_W-1:0]    byte_cnt;
  logic [REC_BITS-1:0] shreg;
`ifdef UART_TX_SCHED_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic [NUM_CH-1:0]   grant_oh;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_any;
  logic [REC_BITS-1:0] rec_sel;
  logic [REC_BITS-1:0] shreg_nxt;
  logic [7:0]          hdr_byte;
  logic [CH_W-1:0]     ptr_nxt;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Granted record, header for the grant, next shifted record and advanced pointer.
  always_comb begin
    rec_sel   = req_data[int'(grant_idx)*REC_BITS +: REC_BITS];
    shreg_nxt = shreg >> 8;
    hdr_byte  = hdr_pack(seq, HDR_CH_W'(grant_idx));
    ptr_nxt   = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
  end

  // Frame FSM: grant, then walk header/payload(/check) bytes on each tx_ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_ack  <= '0;
      tx_ready <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      seq      <= '0;
      byte_cnt <= '0;
`ifdef UART_TX_SCHED_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            shreg    <= rec_sel;
            req_ack  <= grant_oh;
            tx_data  <= hdr_byte;
            tx_ready <= 1'b1;
            rr_ptr   <= ptr_nxt;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= HEADER;
`ifdef UART_TX_SCHED_CHECKSUM_EN
            csum     <= hdr_byte;
`endif
          end
        end
        HEADER: begin
          if (tx_ack) begin
            tx_data <= shreg[7:0];
            state   <= PAYLOAD;
`ifdef UART_TX_SCHED_CHECKSUM_EN
            csum    <= csum ^ shreg[7:0];
`endif
          end
        end
        PAYLOAD: begin
          if (tx_ack) begin
            if (byte_cnt != LAST_BYTE) begin
              shreg    <= shreg_nxt;
              tx_data  <= shreg_nxt[7:0];
              byte_cnt <= byte_cnt + 1'b1;
`ifdef UART_TX_SCHED_CHECKSUM_EN
              csum     <= csum ^ shreg_nxt[7:0];
`endif
            end else begin
              seq <= seq + 1'b1;
`ifdef UART_TX_SCHED_CHECKSUM_EN
              tx_data <= csum;
              state   <= CHECK;
`else
              tx_ready <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
`endif
            end
          end
        end
`ifdef UART_TX_SCHED_CHECKSUM_EN
        CHECK: begin
          if (tx_ack) begin
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: begin
          tx_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a byte scoreboard: expected frame
// bytes are queued when a request is driven and popped as the DUT offers them.
module tb_uart_tx_scheduler;

  localparam int NUM_CH    = 4;
  localparam int REC_BYTES = 4;
`ifdef UART_TX_SCHED_CHECKSUM_EN
  localparam int FRAME_LEN = REC_BYTES + 2;
`else
  localparam int FRAME_LEN = REC_BYTES + 1;
`endif

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic [NUM_CH-1:0]             req_valid = '0;
  logic [NUM_CH*REC_BYTES*8-1:0] req_data = '0;
  logic [NUM_CH-1:0]             req_ack;
  logic [7:0]                    tx_data;
  logic                          tx_ready;
  logic                          tx_ack = 1'b0;
  logic                          busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic [7:0] last_hdr;

  uart_tx_scheduler #(.NUM_CH(NUM_CH), .REC_BYTES(REC_BYTES)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_ack    (tx_ack),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rec_of(input int c);
    return 32'h10203040 ^ {4{8'(c)}};
  endfunction

  // Queue the full expected byte stream of one frame.
  task automatic push_frame(input logic [3:0] s, input int c, input logic [31:0] d);
    logic [7:0] x, b;
    x = {s, 4'(c)};
    sb.push_back(x);
    for (int i = 0; i < REC_BYTES; i++) begin
      b = d[i*8 +: 8];
      sb.push_back(b);
      x = x ^ b;
    end
`ifdef UART_TX_SCHED_CHECKSUM_EN
    sb.push_back(x);
`endif
  endtask

  task automatic wait_grant(input logic [NUM_CH-1:0] exp_ack);
    int w;
    w = 0;
    while (req_ack === '0 && w < 50) begin tick(); w++; end
    check("req_ack", {28'b0, req_ack}, {28'b0, exp_ack});
  endtask

  // Accept n bytes, acking one cycle after each appears; optionally stall before acking byte stall_at.
  task automatic consume(input int n, input int stall_at, input int stall_len);
    logic [7:0] exp, held;
    logic       stable;
    for (int b = 0; b < n; b++) begin
      int w;
      w = 0;
      while (tx_ready !== 1'b1 && w < 50) begin tick(); w++; end
      check("tx_ready", {31'b0, tx_ready}, 32'd1);
      check("busy_in_frame", {31'b0, busy}, 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      if (b == 0) last_hdr = tx_data;
      check("tx_byte", {24'b0, tx_data}, {24'b0, exp});
      if (b == stall_at) begin
        held   = tx_data;
        stable = 1'b1;
        repeat (stall_len) begin
          tick();
          if (tx_data !== held || tx_ready !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", {31'b0, stable}, 32'd1);
      end else begin
        tick();
      end
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic [7:0] hdr_exp [5];
    logic [7:0] d_before;
    hdr_exp = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h40};

    // Reset state
    tick();
    tick();
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h00);
    check("rst_req_ack", {28'b0, req_ack}, 32'h0);
    reset = 1'b0;
    tick();

    // Single request on ch1
    req_data[1*32 +: 32] = 32'h44332211;
    push_frame(4'd0, 1, 32'h44332211);
    req_valid = 4'b0010;
    wait_grant(4'b0010);
    req_valid = '0;
    tick();
    check("req_ack_one_pulse", {28'b0, req_ack}, 32'h0);
    consume(FRAME_LEN, -1, 0);
    check("single_end_ready", {31'b0, tx_ready}, 32'd0);
    check("single_end_busy", {31'b0, busy}, 32'd0);
    check("single_seq", {28'b0, dut.seq}, 32'd1);

    // All four channels valid continuously, from a fresh reset
    do_reset();
    for (int c = 0; c < NUM_CH; c++) req_data[c*32 +: 32] = rec_of(c);
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      int ch;
      ch = int'(hdr_exp[f][3:0]);
      push_frame(hdr_exp[f][7:4], ch, rec_of(ch));
      wait_grant(4'(1 << ch));
      consume(FRAME_LEN, -1, 0);
      check("rr_header", {24'b0, last_hdr}, {24'b0, hdr_exp[f]});
    end
    req_valid = '0;
    tick();
    tick();
    sb.delete();

    // Stall mid-payload on ch3 (seq is now 5)
    req_data[3*32 +: 32] = 32'hDEADBEEF;
    push_frame(4'd5, 3, 32'hDEADBEEF);
    req_valid = 4'b1000;
    wait_grant(4'b1000);
    req_valid = '0;
    consume(FRAME_LEN, 2, 50);
    tick();
    // tx_ack while idle must be ignored
    d_before = tx_data;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    check("idle_ack_ready", {31'b0, tx_ready}, 32'd0);
    check("idle_ack_busy", {31'b0, busy}, 32'd0);
    check("idle_ack_data", {24'b0, tx_data}, {24'b0, d_before});
    check("idle_ack_seq", {28'b0, dut.seq}, 32'd6);

    // Reset while payload byte 2 is offered
    req_data[2*32 +: 32] = 32'hCAFEF00D;
    push_frame(4'd6, 2, 32'hCAFEF00D);
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    req_valid = '0;
    consume(3, -1, 0);
    check("pre_rst_ready", {31'b0, tx_ready}, 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_ready", {31'b0, tx_ready}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_seq", {28'b0, dut.seq}, 32'd0);
    check("midrst_ptr", {30'b0, dut.rr_ptr}, 32'd0);
    check("midrst_data", {24'b0, tx_data}, 32'h00);
    reset = 1'b0;
    sb.delete();
    tick();
    tick();
    check("post_rst_quiet", {31'b0, tx_ready}, 32'd0);
    req_data[3*32 +: 32] = 32'h0badc0de;
    push_frame(4'd0, 3, 32'h0badc0de);
    req_valid = 4'b1000;
    wait_grant(4'b1000);
    req_valid = '0;
    consume(FRAME_LEN, -1, 0);
    check("post_rst_header", {24'b0, last_hdr}, 32'h03);

    // Sequence wrap: 17 frames from ch0 after reset
    do_reset();
    req_data[0 +: 32] = 32'h87654321;
    for (int f = 0; f < 17; f++) begin
      push_frame(4'(f), 0, 32'h87654321);
      req_valid = 4'b0001;
      wait_grant(4'b0001);
      req_valid = '0;
      consume(FRAME_LEN, -1, 0);
    end
    check("seq_wrap_header", {24'b0, last_hdr}, 32'h00);

    // Checksum vector: ch2, 32'h04030201 (checksum byte 06 only when enabled)
    do_reset();
    req_data[2*32 +: 32] = 32'h04030201;
    sb.push_back(8'h02);
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    sb.push_back(8'h03);
    sb.push_back(8'h04);
`ifdef UART_TX_SCHED_CHECKSUM_EN
    sb.push_back(8'h06);
`endif
    req_valid = 4'b0100;
    wait_grant(4'b0100);
    req_valid = '0;
    consume(FRAME_LEN, -1, 0);
    tick();
    check("csum_frame_done", {31'b0, busy}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
